ptw_dcache_arbiter: RTL and testbench

- Sits directly downstream of the MMU page table walker memory port, between it and the L1 data cache request port.
- Merges page-table-walk loads and core LSU loads onto a single registered dcache request channel.
- Routes dcache responses back to the owner by tag.
- Replays nacked walk loads after a backoff; includes an LSU anti-starvation guard.

---
 rtl/ptw_dcache_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_ptw_dcache_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ptw_dcache_arbiter.sv
// Arbiter between the page table walker and the core LSU for the L1 dcache load port.
// Single registered request slot; responses are routed back by dcache tag MSB.
module ptw_dcache_arbiter #(
    parameter int unsigned PADDR_W      = 40,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned TAG_W        = 7,
    parameter int unsigned BACKOFF      = 4,
    parameter int unsigned MAX_RETRY    = 8,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ptw_req_valid_i,
    input  logic [PADDR_W-1:0]   ptw_req_addr_i,
    output logic                 ptw_req_ready_o,
    output logic                 ptw_resp_valid_o,
    output logic [DATA_W-1:0]    ptw_resp_data_o,
    output logic                 ptw_resp_err_o,
    input  logic                 lsu_req_valid_i,
    input  logic [PADDR_W-1:0]   lsu_req_addr_i,
    input  logic [TAG_W-1:0]     lsu_req_tag_i,
    output logic                 lsu_req_ready_o,
    output logic                 lsu_resp_valid_o,
    output logic                 lsu_resp_nack_o,
    output logic [TAG_W-1:0]     lsu_resp_tag_o,
    output logic [DATA_W-1:0]    lsu_resp_data_o,
    output logic                 dc_req_valid_o,
    output logic [PADDR_W-1:0]   dc_req_addr_o,
    output logic [TAG_W:0]       dc_req_tag_o,
    input  logic                 dc_req_ready_i,
    input  logic                 dc_resp_valid_i,
    input  logic                 dc_resp_nack_i,
    input  logic [TAG_W:0]       dc_resp_tag_i,
    input  logic [DATA_W-1:0]    dc_resp_data_i
);

    localparam int unsigned DC_TAG_W = TAG_W + 1;
    localparam int unsigned RETRY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned BO_W     = (BACKOFF > 1) ? $clog2(BACKOFF) : 1;
    localparam int unsigned ST_W     = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    typedef enum logic [1:0] {
        P_IDLE    = 2'd0,
        P_REQ     = 2'd1,
        P_WAIT    = 2'd2,
        P_BACKOFF = 2'd3
    } ptw_state_e;

    ptw_state_e            state_q, state_d;
    logic [PADDR_W-1:0]    ptw_addr_q, ptw_addr_d;
    logic [RETRY_W-1:0]    retry_q, retry_d;
    logic [BO_W-1:0]       backoff_q, backoff_d;
    logic [ST_W-1:0]       starve_q, starve_d;
    logic                  run_q, run_d;
    logic                  dc_valid_q, dc_valid_d;
    logic [PADDR_W-1:0]    dc_addr_q, dc_addr_d;
    logic [DC_TAG_W-1:0]   dc_tag_q, dc_tag_d;
    logic                  presp_valid_q, presp_valid_d;
    logic [DATA_W-1:0]     presp_data_q, presp_data_d;
    logic                  presp_err_q, presp_err_d;

    logic slot_free;
    logic force_lsu;
    logic ptw_grant;
    logic lsu_ready;
    logic lsu_fire;
    logic ptw_accept;
    logic ptw_resp_hit;
    logic lsu_resp_hit;

    // Grant decision; run_q keeps both readies low during and just after reset
    always_comb begin
        slot_free    = !dc_valid_q || dc_req_ready_i;
        force_lsu    = (starve_q == ST_W'(STARVE_LIMIT)) && lsu_req_valid_i;
        ptw_grant    = slot_free && (state_q == P_REQ) && !force_lsu;
        lsu_ready    = run_q && slot_free && !ptw_grant;
        lsu_fire     = lsu_ready && lsu_req_valid_i;
        ptw_accept   = run_q && (state_q == P_IDLE) && ptw_req_valid_i;
        ptw_resp_hit = dc_resp_valid_i && dc_resp_tag_i[DC_TAG_W-1];
        lsu_resp_hit = dc_resp_valid_i && !dc_resp_tag_i[DC_TAG_W-1];
    end

    // Walker FSM: accept, issue, wait for response, back off and replay on nack
    always_comb begin
        state_d       = state_q;
        ptw_addr_d    = ptw_addr_q;
        retry_d       = retry_q;
        backoff_d     = backoff_q;
        presp_valid_d = 1'b0;
        presp_data_d  = presp_data_q;
        presp_err_d   = presp_err_q;
        case (state_q)
            P_IDLE: begin
                if (ptw_accept) begin
                    ptw_addr_d = ptw_req_addr_i;
                    retry_d    = '0;
                    state_d    = P_REQ;
                end
            end
            P_REQ: begin
                if (ptw_grant) state_d = P_WAIT;
            end
            P_WAIT: begin
                if (ptw_resp_hit) begin
                    if (!dc_resp_nack_i) begin
                        presp_valid_d = 1'b1;
                        presp_data_d  = dc_resp_data_i;
                        presp_err_d   = 1'b0;
                        state_d       = P_IDLE;
                    end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
                        retry_d   = retry_q + RETRY_W'(1);
                        backoff_d = '0;
                        state_d   = P_BACKOFF;
                    end else begin
                        presp_valid_d = 1'b1;
                        presp_data_d  = '0;
                        presp_err_d   = 1'b1;
                        state_d       = P_IDLE;
                    end
                end
            end
            P_BACKOFF: begin
                if (backoff_q == BO_W'(BACKOFF - 1)) state_d = P_REQ;
                else backoff_d = backoff_q + BO_W'(1);
            end
            default: state_d = P_IDLE;
        endcase
    end

    // Output slot load/hold and LSU anti-starvation counter
    always_comb begin
        run_d      = 1'b1;
        dc_valid_d = dc_valid_q;
        dc_addr_d  = dc_addr_q;
        dc_tag_d   = dc_tag_q;
        starve_d   = starve_q;
        if (slot_free) begin
            dc_valid_d = ptw_grant || lsu_fire;
            if (ptw_grant) begin
                dc_addr_d = ptw_addr_q;
                dc_tag_d  = {1'b1, TAG_W'(0)};
            end else if (lsu_fire) begin
                dc_addr_d = lsu_req_addr_i;
                dc_tag_d  = {1'b0, lsu_req_tag_i};
            end
        end
        if (!lsu_req_valid_i || lsu_fire) begin
            starve_d = '0;
        end else if (ptw_grant && (starve_q < ST_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + ST_W'(1);
        end
    end

    // State registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= P_IDLE;
            ptw_addr_q    <= '0;
            retry_q       <= '0;
            backoff_q     <= '0;
            starve_q      <= '0;
            run_q         <= 1'b0;
            dc_valid_q    <= 1'b0;
            dc_addr_q     <= '0;
            dc_tag_q      <= '0;
            presp_valid_q <= 1'b0;
            presp_data_q  <= '0;
            presp_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptw_addr_q    <= ptw_addr_d;
            retry_q       <= retry_d;
            backoff_q     <= backoff_d;
            starve_q      <= starve_d;
            run_q         <= run_d;
            dc_valid_q    <= dc_valid_d;
            dc_addr_q     <= dc_addr_d;
            dc_tag_q      <= dc_tag_d;
            presp_valid_q <= presp_valid_d;
            presp_data_q  <= presp_data_d;
            presp_err_q   <= presp_err_d;
        end
    end

    // Output mapping; LSU responses are a gated zero-latency passthrough
    always_comb begin
        ptw_req_ready_o  = run_q && (state_q == P_IDLE);
        ptw_resp_valid_o = presp_valid_q;
        ptw_resp_data_o  = presp_data_q;
        ptw_resp_err_o   = presp_err_q;
        lsu_req_ready_o  = lsu_ready;
        lsu_resp_valid_o = lsu_resp_hit;
        lsu_resp_nack_o  = lsu_resp_hit && dc_resp_nack_i;
        lsu_resp_tag_o   = lsu_resp_hit ? dc_resp_tag_i[TAG_W-1:0] : '0;
        lsu_resp_data_o  = lsu_resp_hit ? dc_resp_data_i : '0;
        dc_req_valid_o   = dc_valid_q;
        dc_req_addr_o    = dc_addr_q;
        dc_req_tag_o     = dc_tag_q;
    end

endmodule

// File: tb/tb_ptw_dcache_arbiter.sv
// Directed bench for ptw_dcache_arbiter with hand-computed expectations.
module tb_ptw_dcache_arbiter;

    localparam int unsigned PADDR_W = 40;
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned TAG_W   = 7;
    localparam int unsigned BACKOFF = 4;

    logic                clk;
    logic                rst_i;
    logic                ptw_req_valid_i;
    logic [PADDR_W-1:0]  ptw_req_addr_i;
    logic                ptw_req_ready_o;
    logic                ptw_resp_valid_o;
    logic [DATA_W-1:0]   ptw_resp_data_o;
    logic                ptw_resp_err_o;
    logic                lsu_req_valid_i;
    logic [PADDR_W-1:0]  lsu_req_addr_i;
    logic [TAG_W-1:0]    lsu_req_tag_i;
    logic                lsu_req_ready_o;
    logic                lsu_resp_valid_o;
    logic                lsu_resp_nack_o;
    logic [TAG_W-1:0]    lsu_resp_tag_o;
    logic [DATA_W-1:0]   lsu_resp_data_o;
    logic                dc_req_valid_o;
    logic [PADDR_W-1:0]  dc_req_addr_o;
    logic [TAG_W:0]      dc_req_tag_o;
    logic                dc_req_ready_i;
    logic                dc_resp_valid_i;
    logic                dc_resp_nack_i;
    logic [TAG_W:0]      dc_resp_tag_i;
    logic [DATA_W-1:0]   dc_resp_data_i;

    int n_vec;
    int n_err;
    logic [PADDR_W-1:0] wa [4];

    ptw_dcache_arbiter #(
        .PADDR_W(PADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W),
        .BACKOFF(BACKOFF), .MAX_RETRY(8), .STARVE_LIMIT(3)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .ptw_req_valid_i(ptw_req_valid_i), .ptw_req_addr_i(ptw_req_addr_i),
        .ptw_req_ready_o(ptw_req_ready_o), .ptw_resp_valid_o(ptw_resp_valid_o),
        .ptw_resp_data_o(ptw_resp_data_o), .ptw_resp_err_o(ptw_resp_err_o),
        .lsu_req_valid_i(lsu_req_valid_i), .lsu_req_addr_i(lsu_req_addr_i),
        .lsu_req_tag_i(lsu_req_tag_i), .lsu_req_ready_o(lsu_req_ready_o),
        .lsu_resp_valid_o(lsu_resp_valid_o), .lsu_resp_nack_o(lsu_resp_nack_o),
        .lsu_resp_tag_o(lsu_resp_tag_o), .lsu_resp_data_o(lsu_resp_data_o),
        .dc_req_valid_o(dc_req_valid_o), .dc_req_addr_o(dc_req_addr_o),
        .dc_req_tag_o(dc_req_tag_o), .dc_req_ready_i(dc_req_ready_i),
        .dc_resp_valid_i(dc_resp_valid_i), .dc_resp_nack_i(dc_resp_nack_i),
        .dc_resp_tag_i(dc_resp_tag_i), .dc_resp_data_i(dc_resp_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Accept a walk from P_IDLE; returns in the cycle its request shows on dc_req
    task automatic start_walk(input logic [PADDR_W-1:0] a);
        ptw_req_valid_i = 1'b1;
        ptw_req_addr_i  = a;
        settle();
        chk("walk_accept_rdy", 64'(ptw_req_ready_o), 64'd1);
        tick();
        ptw_req_valid_i = 1'b0;
        settle();
        chk("walk_preq_rdy", 64'(ptw_req_ready_o), 64'd0);
        tick();
        chk("walk_dc_valid", 64'(dc_req_valid_o), 64'd1);
        chk("walk_dc_addr", 64'(dc_req_addr_o), 64'(a));
        chk("walk_dc_tag", 64'(dc_req_tag_o), 64'h80);
    endtask

    // Nack the outstanding walk; the replay is granted BACKOFF+1 cycles later
    // and becomes visible on dc_req the cycle after that
    task automatic nack_and_replay(input logic [PADDR_W-1:0] a);
        dc_resp_valid_i = 1'b1;
        dc_resp_nack_i  = 1'b1;
        dc_resp_tag_i   = 8'h80;
        dc_resp_data_i  = 64'h0;
        tick();
        dc_resp_valid_i = 1'b0;
        dc_resp_nack_i  = 1'b0;
        settle();
        chk("nack_no_resp", 64'(ptw_resp_valid_o), 64'd0);
        for (int i = 0; i <= int'(BACKOFF); i++) begin
            chk("backoff_idle", 64'(dc_req_valid_o), 64'd0);
            tick();
        end
        chk("replay_valid", 64'(dc_req_valid_o), 64'd1);
        chk("replay_addr", 64'(dc_req_addr_o), 64'(a));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        wa[0] = 40'h80_0000_A000;
        wa[1] = 40'h80_0000_B000;
        wa[2] = 40'h80_0000_C000;
        wa[3] = 40'h80_0000_D000;
        rst_i           = 1'b1;
        ptw_req_valid_i = 1'b0;
        ptw_req_addr_i  = '0;
        lsu_req_valid_i = 1'b0;
        lsu_req_addr_i  = '0;
        lsu_req_tag_i   = '0;
        dc_req_ready_i  = 1'b1;
        dc_resp_valid_i = 1'b0;
        dc_resp_nack_i  = 1'b0;
        dc_resp_tag_i   = '0;
        dc_resp_data_i  = '0;
        tick();
        tick();

        // reset state
        chk("rst_ptw_rdy", 64'(ptw_req_ready_o), 64'd0);
        chk("rst_lsu_rdy", 64'(lsu_req_ready_o), 64'd0);
        chk("rst_dc_valid", 64'(dc_req_valid_o), 64'd0);
        chk("rst_dc_tag", 64'(dc_req_tag_o), 64'd0);
        chk("rst_ptw_resp", 64'(ptw_resp_valid_o), 64'd0);
        chk("rst_lsu_resp", 64'(lsu_resp_valid_o), 64'd0);
        rst_i = 1'b0;
        tick();
        chk("run_ptw_rdy", 64'(ptw_req_ready_o), 64'd1);
        chk("run_lsu_rdy", 64'(lsu_req_ready_o), 64'd1);

        // single walk, no LSU traffic
        ptw_req_valid_i = 1'b1;
        ptw_req_addr_i  = 40'h00_8000_1000;
        tick();
        ptw_req_valid_i = 1'b0;
        settle();
        chk("a_dc_not_yet", 64'(dc_req_valid_o), 64'd0);
        tick();
        chk("a_dc_valid", 64'(dc_req_valid_o), 64'd1);
        chk("a_dc_addr", 64'(dc_req_addr_o), 64'h8000_1000);
        chk("a_dc_tag", 64'(dc_req_tag_o), 64'h80);
        tick();
        chk("a_dc_drained", 64'(dc_req_valid_o), 64'd0);
        dc_resp_valid_i = 1'b1;
        dc_resp_tag_i   = 8'h80;
        dc_resp_data_i  = 64'hDEAD;
        settle();
        chk("a_not_lsu", 64'(lsu_resp_valid_o), 64'd0);
        tick();
        dc_resp_valid_i = 1'b0;
        settle();
        chk("a_resp_valid", 64'(ptw_resp_valid_o), 64'd1);
        chk("a_resp_data", 64'(ptw_resp_data_o), 64'hDEAD);
        chk("a_resp_err", 64'(ptw_resp_err_o), 64'd0);
        chk("a_idle_rdy", 64'(ptw_req_ready_o), 64'd1);
        tick();
        chk("a_resp_pulse", 64'(ptw_resp_valid_o), 64'd0);

        // PTW in P_REQ beats a waiting LSU when starve is 0
        ptw_req_valid_i = 1'b1;
        ptw_req_addr_i  = 40'h00_8000_2000;
        tick();
        ptw_req_valid_i = 1'b0;
        lsu_req_valid_i = 1'b1;
        lsu_req_tag_i   = 7'h15;
        lsu_req_addr_i  = 40'h1000;
        settle();
        chk("b_lsu_blocked", 64'(lsu_req_ready_o), 64'd0);
        tick();
        chk("b_ptw_first", 64'(dc_req_tag_o), 64'h80);
        chk("b_lsu_next", 64'(lsu_req_ready_o), 64'd1);
        tick();
        lsu_req_valid_i = 1'b0;
        dc_resp_valid_i = 1'b1;
        dc_resp_tag_i   = 8'h15;
        dc_resp_data_i  = 64'hBEEF;
        settle();
        chk("b_dc_lsu_tag", 64'(dc_req_tag_o), 64'h15);
        chk("b_dc_lsu_addr", 64'(dc_req_addr_o), 64'h1000);
        chk("b_lsu_resp_v", 64'(lsu_resp_valid_o), 64'd1);
        chk("b_lsu_resp_tag", 64'(lsu_resp_tag_o), 64'h15);
        chk("b_lsu_resp_data", 64'(lsu_resp_data_o), 64'hBEEF);
        chk("b_lsu_resp_nack", 64'(lsu_resp_nack_o), 64'd0);
        tick();
        dc_resp_tag_i  = 8'h80;
        dc_resp_data_i = 64'h1234;
        tick();
        dc_resp_valid_i = 1'b1;
        dc_resp_nack_i  = 1'b1;
        dc_resp_tag_i   = 8'h7F;
        dc_resp_data_i  = 64'h55;
        settle();
        chk("b_ptw_resp", 64'(ptw_resp_data_o), 64'h1234);
        chk("b_nack_pass", 64'(lsu_resp_nack_o), 64'd1);
        chk("b_nack_tag", 64'(lsu_resp_tag_o), 64'h7F);
        tick();
        dc_resp_nack_i = 1'b0;
        dc_resp_tag_i  = 8'h80;
        dc_resp_data_i = 64'h9999;
        tick();
        dc_resp_valid_i = 1'b0;
        settle();
        chk("b_stray_drop", 64'(ptw_resp_valid_o), 64'd0);
        chk("b_stray_idle", 64'(ptw_req_ready_o), 64'd1);

        // backpressure: slot held stable, no accepts, then drain plus refill
        dc_req_ready_i  = 1'b0;
        lsu_req_valid_i = 1'b1;
        lsu_req_tag_i   = 7'h21;
        lsu_req_addr_i  = 40'h2000;
        tick();
        lsu_req_tag_i  = 7'h22;
        lsu_req_addr_i = 40'h3000;
        settle();
        for (int i = 0; i < 5; i++) begin
            chk("c_hold_addr", 64'(dc_req_addr_o), 64'h2000);
            chk("c_hold_tag", 64'(dc_req_tag_o), 64'h21);
            chk("c_no_accept", 64'(lsu_req_ready_o), 64'd0);
            tick();
        end
        dc_req_ready_i = 1'b1;
        settle();
        chk("c_refill_rdy", 64'(lsu_req_ready_o), 64'd1);
        tick();
        lsu_req_valid_i = 1'b0;
        settle();
        chk("c_refill_tag", 64'(dc_req_tag_o), 64'h22);
        chk("c_refill_addr", 64'(dc_req_addr_o), 64'h3000);
        tick();
        chk("c_drained", 64'(dc_req_valid_o), 64'd0);

        // two nacks with replay, then success
        start_walk(40'h00_8000_3000);
        nack_and_replay(40'h00_8000_3000);
        nack_and_replay(40'h00_8000_3000);
        dc_resp_valid_i = 1'b1;
        dc_resp_tag_i   = 8'h80;
        dc_resp_data_i  = 64'hCAFE;
        tick();
        dc_resp_valid_i = 1'b0;
        settle();
        chk("d_resp_valid", 64'(ptw_resp_valid_o), 64'd1);
        chk("d_resp_err", 64'(ptw_resp_err_o), 64'd0);
        chk("d_resp_data", 64'(ptw_resp_data_o), 64'hCAFE);
        tick();

        // retry budget exhausted on the ninth nack
        start_walk(40'h00_8000_4000);
        for (int i = 0; i < 8; i++) nack_and_replay(40'h00_8000_4000);
        dc_resp_valid_i = 1'b1;
        dc_resp_nack_i  = 1'b1;
        dc_resp_tag_i   = 8'h80;
        dc_resp_data_i  = 64'hFFFF;
        tick();
        dc_resp_valid_i = 1'b0;
        dc_resp_nack_i  = 1'b0;
        settle();
        chk("e_err_valid", 64'(ptw_resp_valid_o), 64'd1);
        chk("e_err_flag", 64'(ptw_resp_err_o), 64'd1);
        chk("e_err_data", 64'(ptw_resp_data_o), 64'd0);
        chk("e_idle_rdy", 64'(ptw_req_ready_o), 64'd1);
        tick();

        // starvation guard: dcache answers while holding ready low so the
        // LSU never sees a free slot outside P_REQ
        dc_req_ready_i  = 1'b0;
        lsu_req_valid_i = 1'b1;
        lsu_req_tag_i   = 7'h33;
        lsu_req_addr_i  = 40'h5000;
        ptw_req_valid_i = 1'b1;
        ptw_req_addr_i  = wa[0];
        settle();
        chk("f_both_ptw_rdy", 64'(ptw_req_ready_o), 64'd1);
        chk("f_both_lsu_rdy", 64'(lsu_req_ready_o), 64'd1);
        tick();
        ptw_req_valid_i = 1'b0;
        lsu_req_tag_i   = 7'h34;
        lsu_req_addr_i  = 40'h5040;
        dc_req_ready_i  = 1'b1;
        settle();
        chk("f_lsu_in_slot", 64'(dc_req_tag_o), 64'h33);
        for (int i = 0; i < 3; i++) begin
            chk("f_lsu_wait", 64'(lsu_req_ready_o), 64'd0);
            tick();
            dc_req_ready_i = 1'b0;
            settle();
            chk("f_ptw_tag", 64'(dc_req_tag_o), 64'h80);
            chk("f_ptw_addr", 64'(dc_req_addr_o), 64'(wa[i]));
            dc_resp_valid_i = 1'b1;
            dc_resp_tag_i   = 8'h80;
            dc_resp_data_i  = 64'(32'h100 + i);
            tick();
            dc_resp_valid_i = 1'b0;
            ptw_req_valid_i = 1'b1;
            ptw_req_addr_i  = wa[i+1];
            settle();
            chk("f_reaccept", 64'(ptw_req_ready_o), 64'd1);
            tick();
            ptw_req_valid_i = 1'b0;
            dc_req_ready_i  = 1'b1;
            settle();
        end
        chk("f_lsu_forced", 64'(lsu_req_ready_o), 64'd1);
        tick();
        lsu_req_valid_i = 1'b0;
        settle();
        chk("f_forced_tag", 64'(dc_req_tag_o), 64'h34);
        chk("f_forced_addr", 64'(dc_req_addr_o), 64'h5040);
        chk("f_ptw_after", 64'(lsu_req_ready_o), 64'd0);
        tick();
        chk("f_ptw4_tag", 64'(dc_req_tag_o), 64'h80);
        chk("f_ptw4_addr", 64'(dc_req_addr_o), 64'(wa[3]));

        // reset mid-P_WAIT clears outputs at once; a late response is dropped
        #2;
        rst_i = 1'b1;
        #1;
        chk("g_dc_valid", 64'(dc_req_valid_o), 64'd0);
        chk("g_dc_addr", 64'(dc_req_addr_o), 64'd0);
        chk("g_dc_tag", 64'(dc_req_tag_o), 64'd0);
        chk("g_ptw_rdy", 64'(ptw_req_ready_o), 64'd0);
        chk("g_lsu_rdy", 64'(lsu_req_ready_o), 64'd0);
        chk("g_ptw_data", 64'(ptw_resp_data_o), 64'd0);
        chk("g_ptw_err", 64'(ptw_resp_err_o), 64'd0);
        tick();
        rst_i = 1'b0;
        tick();
        tick();
        dc_resp_valid_i = 1'b1;
        dc_resp_tag_i   = 8'h80;
        dc_resp_data_i  = 64'h7777;
        tick();
        dc_resp_valid_i = 1'b0;
        settle();
        chk("g_late_drop", 64'(ptw_resp_valid_o), 64'd0);
        chk("g_idle_rdy", 64'(ptw_req_ready_o), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
